// File: rtl/forthsuper_pkg.sv
// rtl/forthsuper_pkg.sv - shared types, result codes and character helpers for number parsing
package forthsuper_pkg;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_SKIP = 3'd1,
        ST_PFX  = 3'd2,
        ST_CNV  = 3'd3,
        ST_DONE = 3'd4
    } numparse_sts;

    localparam logic [1:0] NP_OK    = 2'd0;
    localparam logic [1:0] NP_EMPTY = 2'd1;
    localparam logic [1:0] NP_BAD   = 2'd2;
    localparam logic [1:0] NP_LONG  = 2'd3;

    localparam logic [7:0] CH_SP     = 8'h20;
    localparam logic [7:0] CH_NUL    = 8'h00;
    localparam logic [7:0] CH_DOLLAR = 8'h24;
    localparam logic [7:0] CH_HASH   = 8'h23;
    localparam logic [7:0] CH_MINUS  = 8'h2D;

    function automatic logic is_dec(input logic [7:0] c);
        return (c >= 8'h30) && (c <= 8'h39);
    endfunction

    function automatic logic is_hex_alpha(input logic [7:0] c);
        return ((c >= 8'h61) && (c <= 8'h66)) || ((c >= 8'h41) && (c <= 8'h46));
    endfunction

    // Low nibble is the value for '0'-'9'; letters sit at 0x41/0x61, so +9 maps them to 10..15
    function automatic logic [3:0] digit_val(input logic [7:0] c);
        return is_dec(c) ? c[3:0] : (c[3:0] + 4'd9);
    endfunction

endpackage

// File: rtl/numparse_ctl_atoi.sv
// rtl/numparse_ctl_atoi.sv - streaming ascii-to-integer core, one character per two cycles
import forthsuper_pkg::*;

module atoi #(
    parameter int DSZ = 32
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           en,
    input  logic           hex,
    input  logic [7:0]     md,
    output logic           af,
    output logic           bsy,
    output logic [DSZ-1:0] vo
);

    logic           ph_q, ph_d;        // 0: data cycle (md valid), 1: read-wait cycle
    logic           fin_q, fin_d;
    logic           first_q, first_d;  // sign is only legal on the first character
    logic           neg_q, neg_d;
    logic [DSZ-1:0] acc_q, acc_d;

    assign bsy = en & ~fin_q;
    assign af  = en & ~fin_q & ~ph_q;
    assign vo  = neg_q ? (DSZ'(0) - acc_q) : acc_q;

    // Consume one character per data cycle; any non-digit (other than a leading sign) ends the run
    always_comb begin
        ph_d    = ph_q;
        fin_d   = fin_q;
        first_d = first_q;
        neg_d   = neg_q;
        acc_d   = acc_q;
        if (!en) begin
            ph_d    = 1'b0;
            fin_d   = 1'b0;
            first_d = 1'b1;
            neg_d   = 1'b0;
            acc_d   = '0;
        end else if (!fin_q) begin
            if (!ph_q) begin
                ph_d    = 1'b1;
                first_d = 1'b0;
                if (is_dec(md) || is_hex_alpha(md)) begin
                    acc_d = (hex ? {acc_q[DSZ-5:0], 4'h0} : (acc_q * DSZ'(10)))
                            + DSZ'(digit_val(md));
                end else if ((md == CH_MINUS) && first_q) begin
                    neg_d = 1'b1;
                end else begin
                    fin_d = 1'b1;
                end
            end else begin
                ph_d = 1'b0;
            end
        end
    end

    // Core state register
    always_ff @(posedge clk) begin
        if (rst) begin
            ph_q    <= 1'b0;
            fin_q   <= 1'b0;
            first_q <= 1'b1;
            neg_q   <= 1'b0;
            acc_q   <= '0;
        end else begin
            ph_q    <= ph_d;
            fin_q   <= fin_d;
            first_q <= first_d;
            neg_q   <= neg_d;
            acc_q   <= acc_d;
        end
    end

endmodule

// File: rtl/numparse_ctl.sv
// rtl/numparse_ctl.sv - number-literal sequencer: skip, prefix, convert, validate, report
import forthsuper_pkg::*;

module numparse_ctl #(
    parameter int DSZ  = 32,
    parameter int ASZ  = 17,
    parameter int MAXD = 10
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           req,
    input  logic [ASZ-1:0] ta,
    input  logic           base_hex,
    input  logic [7:0]     md,
    output logic [ASZ-1:0] ma,
    output logic           bsy,
    output logic           ack,
    output logic [1:0]     ecode,
    output logic [DSZ-1:0] vo,
    output logic [ASZ-1:0] ea
);

    localparam int             NDW    = $clog2(MAXD + 2);
    localparam logic [NDW-1:0] ND_SAT = NDW'(MAXD + 1);

    numparse_sts    state_q, state_d;
    logic           ph_q, ph_d;        // SKIP: address/data phase; PFX: read-wait after a prefix
    logic           hex_q, hex_d;
    logic [NDW-1:0] nd_q, nd_d;
    logic           bad_q, bad_d;
    logic           cbsy_q;
    logic [ASZ-1:0] ma_q, ma_d;
    logic           ack_q, ack_d;
    logic           bsy_q, bsy_d;
    logic [1:0]     ecode_q, ecode_d;
    logic [DSZ-1:0] vo_q, vo_d;
    logic [ASZ-1:0] ea_q, ea_d;

    logic           c_en;
    logic           c_af;
    logic           c_bsy;
    logic [DSZ-1:0] c_vo;
    logic           c_fall;
    logic [1:0]     rc;

    function automatic logic [1:0] result_code(input logic [NDW-1:0] n, input logic b,
                                               input logic [7:0] term);
        if (n == '0)                                    return NP_EMPTY;
        if (b || ((term != CH_NUL) && (term != CH_SP))) return NP_BAD;
        if (n > NDW'(MAXD))                             return NP_LONG;
        return NP_OK;
    endfunction

    atoi #(.DSZ(DSZ)) a2i (
        .clk (clk),
        .rst (rst),
        .en  (c_en),
        .hex (hex_q),
        .md  (md),
        .af  (c_af),
        .bsy (c_bsy),
        .vo  (c_vo)
    );

    assign c_fall = cbsy_q & ~c_bsy;
    assign rc     = result_code(nd_q, bad_q, md);

    assign ma    = ma_q;
    assign bsy   = bsy_q;
    assign ack   = ack_q;
    assign ecode = ecode_q;
    assign vo    = vo_q;
    assign ea    = ea_q;

    // State register
    always_ff @(posedge clk) begin
        if (rst) state_q <= ST_IDLE;
        else     state_q <= state_d;
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: if (req) state_d = ST_SKIP;
            ST_SKIP: begin
                if (ph_q) begin
                    if (md == CH_NUL)     state_d = ST_DONE;
                    else if (md != CH_SP) state_d = ST_PFX;
                end
            end
            ST_PFX: begin
                if (ph_q)                                        state_d = ST_CNV;
                else if ((md != CH_DOLLAR) && (md != CH_HASH))   state_d = ST_CNV;
            end
            ST_CNV:  if (c_fall) state_d = ST_DONE;
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    // Datapath and output values for the next cycle
    always_comb begin
        ph_d    = ph_q;
        hex_d   = hex_q;
        nd_d    = nd_q;
        bad_d   = bad_q;
        ma_d    = ma_q;
        ecode_d = ecode_q;
        vo_d    = vo_q;
        ea_d    = ea_q;
        c_en    = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (req) begin
                    ma_d  = ta;
                    hex_d = base_hex;
                    nd_d  = '0;
                    bad_d = 1'b0;
                    ph_d  = 1'b0;
                end
            end
            ST_SKIP: begin
                ph_d = ~ph_q;
                if (ph_q) begin
                    if (md == CH_SP) begin
                        ma_d = ma_q + ASZ'(1);
                    end else if (md == CH_NUL) begin
                        ecode_d = NP_EMPTY;
                        vo_d    = '0;
                        ea_d    = ma_q + ASZ'(1);
                    end
                end
            end
            ST_PFX: begin
                ph_d = 1'b0;
                if (!ph_q) begin
                    if (md == CH_DOLLAR) begin
                        hex_d = 1'b1;
                        ma_d  = ma_q + ASZ'(1);
                        ph_d  = 1'b1;
                    end else if (md == CH_HASH) begin
                        hex_d = 1'b0;
                        ma_d  = ma_q + ASZ'(1);
                        ph_d  = 1'b1;
                    end
                end
            end
            ST_CNV: begin
                c_en = 1'b1;
                ma_d = ma_q + ASZ'(c_af);
                if (c_af) begin
                    // The core takes a-f even in decimal, so the controller must flag them
                    if (is_dec(md) || (is_hex_alpha(md) && hex_q)) begin
                        if (nd_q != ND_SAT) nd_d = nd_q + NDW'(1);
                    end else if (is_hex_alpha(md)) begin
                        bad_d = 1'b1;
                    end
                end
                if (c_fall) begin
                    ea_d    = ma_q;
                    ecode_d = rc;
                    vo_d    = (rc == NP_OK) ? c_vo : '0;
                end
            end
            default: ;
        endcase
        ack_d = (state_d == ST_DONE);
        bsy_d = (state_d != ST_IDLE);
    end

    // Registered outputs and working registers
    always_ff @(posedge clk) begin
        if (rst) begin
            ph_q    <= 1'b0;
            hex_q   <= 1'b0;
            nd_q    <= '0;
            bad_q   <= 1'b0;
            cbsy_q  <= 1'b0;
            ma_q    <= '0;
            ack_q   <= 1'b0;
            bsy_q   <= 1'b0;
            ecode_q <= NP_OK;
            vo_q    <= '0;
            ea_q    <= '0;
        end else begin
            ph_q    <= ph_d;
            hex_q   <= hex_d;
            nd_q    <= nd_d;
            bad_q   <= bad_d;
            cbsy_q  <= c_bsy;
            ma_q    <= ma_d;
            ack_q   <= ack_d;
            bsy_q   <= bsy_d;
            ecode_q <= ecode_d;
            vo_q    <= vo_d;
            ea_q    <= ea_d;
        end
    end

endmodule

// File: tb/tb_numparse_ctl.sv
// tb/tb_numparse_ctl.sv - scoreboard bench for numparse_ctl
module tb_numparse_ctl;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        req = 1'b0;
    logic [16:0] ta = '0;
    logic        base_hex = 1'b0;
    logic [7:0]  md = '0;
    logic [16:0] ma;
    logic        bsy;
    logic        ack;
    logic [1:0]  ecode;
    logic [31:0] vo;
    logic [16:0] ea;

    logic [7:0]  mem [0:131071];
    int          cyc = 0;
    int          total = 0;
    int          bad = 0;
    logic        ack_prev = 1'b0;

    typedef struct {
        logic [1:0]  ec;
        logic [31:0] v;
        logic [16:0] a;
        bit          chk_a;
        int          lat;
        int          t0;
        string       name;
    } exp_t;

    exp_t exp_q[$];
    exp_t e;

    numparse_ctl #(.DSZ(32), .ASZ(17), .MAXD(10)) dut (
        .clk      (clk),
        .rst      (rst),
        .req      (req),
        .ta       (ta),
        .base_hex (base_hex),
        .md       (md),
        .ma       (ma),
        .bsy      (bsy),
        .ack      (ack),
        .ecode    (ecode),
        .vo       (vo),
        .ea       (ea)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        cyc <= cyc + 1;
        md  <= mem[ma];
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", name, act, exp);
        end
    endtask

    // Monitor: every ack pops one expectation
    always @(negedge clk) begin
        if (!rst) begin
            if (ack) begin
                chk("ack_one_cycle", {31'd0, ack_prev}, 32'd0);
                chk("bsy_with_ack", {31'd0, bsy}, 32'd1);
                if (exp_q.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL unexpected_ack: got ack want none");
                end else begin
                    e = exp_q.pop_front();
                    chk({e.name, "_ecode"}, {30'd0, ecode}, {30'd0, e.ec});
                    chk({e.name, "_vo"}, vo, e.v);
                    if (e.chk_a) chk({e.name, "_ea"}, {15'd0, ea}, {15'd0, e.a});
                    if (e.lat >= 0) chk({e.name, "_lat"}, cyc - e.t0, e.lat);
                end
            end
            ack_prev <= ack;
        end else begin
            ack_prev <= 1'b0;
        end
    end

    task automatic load(input logic [16:0] a, input string s);
        for (int i = 0; i < s.len(); i++) mem[17'(a + 17'(i))] = s[i];
    endtask

    task automatic expect_res(input string name, input logic [1:0] ec, input logic [31:0] v,
                              input logic [16:0] a, input bit chk_a, input int lat);
        exp_t x;
        x.name = name; x.ec = ec; x.v = v; x.a = a; x.chk_a = chk_a; x.lat = lat; x.t0 = cyc;
        exp_q.push_back(x);
    endtask

    task automatic wait_idle(input string name);
        int n;
        n = 0;
        while (bsy && n < 400) begin
            @(negedge clk);
            n++;
        end
        if (bsy) begin
            total++;
            bad++;
            $display("FAIL %s_timeout: bsy still %0d want 0", name, bsy);
        end
        @(negedge clk);
    endtask

    task automatic parse(input string name, input logic [16:0] a, input logic h,
                         input logic [1:0] ec, input logic [31:0] v,
                         input logic [16:0] ea_exp, input bit chk_a, input int lat);
        req = 1'b1; ta = a; base_hex = h;
        expect_res(name, ec, v, ea_exp, chk_a, lat);
        @(negedge clk);
        req = 1'b0;
        wait_idle(name);
    endtask

    initial begin
        for (int i = 0; i < 131072; i++) mem[i] = 8'h00;
        load(17'h00100, "  123 ");
        load(17'h00200, "$-1f");
        load(17'h00300, "12a ");
        load(17'h00400, " ");
        load(17'h00500, "$ ");
        load(17'h00600, "12345678901 ");
        load(17'h00700, "12x");
        load(17'h00800, "#1f ");
        load(17'h00900, "ff ");
        load(17'h00A00, "1234567890 ");
        load(17'h00B00, "98765 ");
        load(17'h00C00, "7 ");
        load(17'h1FFFE, "7 ");

        repeat (3) @(negedge clk);
        chk("rst_ma", {15'd0, ma}, 32'd0);
        chk("rst_ack", {31'd0, ack}, 32'd0);
        chk("rst_bsy", {31'd0, bsy}, 32'd0);
        chk("rst_ecode", {30'd0, ecode}, 32'd0);
        chk("rst_vo", vo, 32'd0);
        chk("rst_ea", {15'd0, ea}, 32'd0);
        rst = 1'b0;
        @(negedge clk);

        parse("spaces123", 17'h00100, 1'b0, 2'd0, 32'd123,        17'h00106, 1'b1, 16);
        parse("neg_hex",   17'h00200, 1'b0, 2'd0, 32'hFFFF_FFE1,  17'h00205, 1'b1, 13);
        parse("dec_12a",   17'h00300, 1'b0, 2'd2, 32'd0,          17'h00304, 1'b1, 12);
        parse("hex_12a",   17'h00300, 1'b1, 2'd0, 32'h0000_012A,  17'h00304, 1'b1, 12);
        parse("space_nul", 17'h00400, 1'b0, 2'd1, 32'd0,          17'h00000, 1'b0, 5);
        parse("pfx_only",  17'h00500, 1'b0, 2'd1, 32'd0,          17'h00502, 1'b1, 7);
        parse("too_long",  17'h00600, 1'b0, 2'd3, 32'd0,          17'h0060C, 1'b1, -1);
        parse("bad_term",  17'h00700, 1'b0, 2'd2, 32'd0,          17'h00703, 1'b1, -1);
        parse("hash_1f",   17'h00800, 1'b1, 2'd2, 32'd0,          17'h00804, 1'b1, -1);
        parse("hex_ff",    17'h00900, 1'b1, 2'd0, 32'h0000_00FF,  17'h00903, 1'b1, 10);
        parse("ten_dig",   17'h00A00, 1'b0, 2'd0, 32'd1234567890, 17'h00A0B, 1'b1, -1);
        parse("wrap",      17'h1FFFE, 1'b0, 2'd0, 32'd7,          17'h00000, 1'b1, 8);

        // Reset in the middle of conversion: no ack, everything cleared
        req = 1'b1; ta = 17'h00B00; base_hex = 1'b0;
        @(negedge clk);
        req = 1'b0;
        repeat (8) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        chk("midrst_bsy", {31'd0, bsy}, 32'd0);
        chk("midrst_ack", {31'd0, ack}, 32'd0);
        chk("midrst_ma", {15'd0, ma}, 32'd0);
        chk("midrst_ecode", {30'd0, ecode}, 32'd0);
        chk("midrst_vo", vo, 32'd0);
        chk("midrst_ea", {15'd0, ea}, 32'd0);
        rst = 1'b0;
        repeat (20) @(negedge clk);

        // Second req held high while busy must be ignored
        req = 1'b1; ta = 17'h00C00; base_hex = 1'b0;
        expect_res("after_rst", 2'd0, 32'd7, 17'h00C02, 1'b1, 8);
        @(negedge clk);
        ta = 17'h00100;
        repeat (3) @(negedge clk);
        req = 1'b0;
        wait_idle("after_rst");
        repeat (5) @(negedge clk);

        total++;
        if (exp_q.size() != 0) begin
            bad++;
            $display("FAIL pending_results: got %0d want 0", exp_q.size());
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/numparse_ctl.md
# numparse_ctl

Number-literal sequencer for the outer interpreter. Given the address of a whitespace-delimited token in byte memory, it:
- skips leading spaces and resolves a base prefix;
- sequences one `atoi` core instance across the digit string;
- validates every consumed character, the terminator and the digit count;
- returns the value, an error code and the end-of-token address with a single-cycle `ack`.

It sits between the interpreter state machine (after dictionary lookup fails) and the 8-bit memory read port.

## Interface
Parameters:
- `DSZ`, 32: result width, passed to the `atoi` core.
- `ASZ`, 17: byte address width.
- `MAXD`, 10: maximum accepted digit count in any base.

Ports:
- `clk`  in  1: clock.
- `rst`  in  1: reset. One clock; reset is synchronous and active-high.
- `req`  in  1: start parse. Sampled only in IDLE.
- `ta`  in  ASZ: token start address, sampled with `req`.
- `base_hex`  in  1: default base from BASE (0 = decimal, 1 = hex), sampled with `req`.
- `md`  in  8: memory read data. Registered memory: `md` reflects the `ma` held during the previous cycle.
- `ma`  out  ASZ: memory read address.
- `bsy`  out  1: high from `req` acceptance up to and including the `ack` cycle.
- `ack`  out  1: one-cycle completion pulse.
- `ecode`  out  2: result code, valid with `ack`. 0 = ok, 1 = empty, 2 = bad digit or terminator, 3 = too many digits.
- `vo`  out  DSZ: value. Valid with `ack`, forced to 0 when `ecode` ≠ 0.
- `ea`  out  ASZ: address one past the terminator, valid with `ack`.

## Operation
- States: IDLE, SKIP, PFX, CNV, DONE.
- IDLE:
  - On `req`: `ma` <= `ta`, latch `hex` <= `base_hex`, clear the digit counter `nd` and the bad-digit flag, go to SKIP.
  - `req` while not in IDLE is ignored.
- SKIP: each character costs 2 cycles (address cycle, then data cycle). On the data cycle:
  - `md` = 0x20: `ma` += 1, stay in SKIP.
  - `md` = 0x00: DONE with `ecode` = 1.
  - Any other value: go to PFX without advancing.
- PFX, one data cycle:
  - `$`: `hex` <= 1, `ma` += 1.
  - `#`: `hex` <= 0, `ma` += 1.
  - Any other value: no change.
  - Then go to CNV after one read-wait cycle.
- CNV:
  - Core `en` = 1, core `hex` = latched `hex`, `ma` += core `af` every cycle.
  - Sign `-` is handled by the core. It is legal only immediately after the prefix (e.g. `$-1f`).
  - The controller classifies `md` on each core `af` cycle:
    - Decimal digit in either base: counted, `nd` += 1.
    - `a`–`f` / `A`–`F`: counted only when `hex` = 1. When `hex` = 0 they set the bad flag, because the core accepts them in decimal.
  - On the core `bsy` falling edge (1→0):
    - Register `term` = `md`.
    - Drive `ea` = `ma`.
    - Drop core `en`.
    - Go to DONE.
- DONE, one cycle: `ack` = 1. Result priority:
  - `nd` = 0 → 1.
  - Bad flag set, or `term` ∉ {0x00, 0x20} → 2.
  - `nd` > `MAXD` → 3.
  - Otherwise 0.
  - `vo` = core `vo` when `ecode` = 0, else 0. Next state IDLE.
- Arithmetic: no overflow detection beyond the `MAXD` digit limit. Core wrap-around inside DSZ is accepted. `nd` saturates at `MAXD`+1.
- `ma` wraps modulo 2^ASZ, with no error.

## Timing
- Reset: on `rst`, state = IDLE. At the next edge `ma`, `vo`, `ea`, `ecode`, `ack` and `bsy` all = 0, and core `en` = 0. Reset mid-parse abandons the parse with no `ack`.
- Latency from `req` to `ack`, for a token with s leading spaces and p prefix chars (0 or 1):
  - 2(s+1) cycles for SKIP.
  - p + 1 cycles for PFX plus the read wait.
  - The CNV length set by the core (2 cycles per character including the terminator).
  - 1 cycle for DONE.
- `ack` and `bsy` end on the same cycle. `req` is accepted at the earliest on the cycle after `ack`.
- `vo`, `ecode` and `ea` hold their values until the next `ack` or `rst`.

## Structure
- Shared package `forthsuper_pkg`:
  - `numparse_sts` enum (IDLE..DONE).
  - `ecode` localparams (`NP_OK`, `NP_EMPTY`, `NP_BAD`, `NP_LONG`).
  - Character constants (space, NUL, `$`, `#`).
- One sub-module: `atoi` core instance `a2i`. This block owns `ma`; the core's `af` is its only address-advance source during CNV.
- 4-block FSM: state register, next-state comb, output comb, registered outputs.

## Test plan
- "␠␠123␠", `base_hex`=0 → `ecode`=0, `vo`=123, `ea` = `ta`+6, `ack` exactly one cycle.
- "$-1f", NUL, `base_hex`=0 → `ecode`=0, `vo`=-31 (0xFFFF_FFE1).
- "12a␠", `base_hex`=0 → `ecode`=2, `vo`=0. The same string with `base_hex`=1 → `vo`=0x12A, `ecode`=0.
- "␠", NUL → `ecode`=1. "$␠" → `ecode`=1. "12345678901␠" (decimal) → `ecode`=3, `vo`=0.
- "12x" → `ecode`=2. "#ff␠" with `base_hex`=1 → `ecode`=2.
- `rst` pulsed during CNV of "98765␠":
  - Next edge: IDLE, all outputs 0, no `ack`.
  - Then a new `req` on "7␠" → `vo`=7, `ecode`=0.
  - A second `req` held high while `bsy` is ignored.
